// File: rtl/fetch_unit.sv
// Instruction fetch unit: a single-entry instruction buffer fed by a one-outstanding-request
// memory port, with branch/jump redirects that drop any response still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic        jump,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        flush,
  output logic        misaligned
);

  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic        redirect;
  logic        req;

  assign redirect = branch | jump;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_VECTOR;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    mis_d     = 1'b0;
    req       = 1'b0;

    // Consumption clears the buffer; a load later in this block overrides it.
    if (valid_q && !stall) valid_d = 1'b0;

    case (state_q)
      FETCH: begin
        if (!redirect && (!valid_q || !stall)) begin
          req     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = FETCH;
          if (!redirect) begin
            inst_d    = mem_data;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 32'd4;
          end
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (redirect) begin
      pc_d    = {target[31:2], 2'b00};
      valid_d = 1'b0;
      mis_d   = (target[1:0] != 2'b00);
    end
  end

  // Request is masked while reset is held so nothing issues before release.
  assign mem_req    = req & rst;
  assign mem_addr   = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign flush      = redirect;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirects, misalignment,
// a wrapping reset vector and mid-request reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        branch, jump, stall;
  logic [31:0] target;
  logic        mem_ack, mem_ack2;
  logic [31:0] mem_data;

  logic        mem_req, inst_valid, flush, misaligned;
  logic [31:0] mem_addr, inst, inst_pc;
  logic        mem_req2, inst_valid2, flush2, misaligned2;
  logic [31:0] mem_addr2, inst2, inst_pc2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .branch(branch), .jump(jump), .target(target), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .flush(flush),
    .misaligned(misaligned)
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .rst(rst2), .branch(branch), .jump(jump), .target(target), .stall(stall),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_data(mem_data),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2), .flush(flush2),
    .misaligned(misaligned2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rst2 = 1'b0;
    branch = 1'b0; jump = 1'b0; stall = 1'b0; target = 32'h0;
    mem_ack = 1'b0; mem_ack2 = 1'b0; mem_data = 32'h0;

    repeat (3) tick();
    #1;
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_mis", misaligned, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst2_addr", mem_addr2, 32'hFFFF_FFFC);

    // Sequential fetch, ack one cycle after each request
    rst = 1'b1;
    #1;
    chk("req0", mem_req, 1'b1);
    chk("addr0", mem_addr, 32'h0);
    tick(); mem_ack = 1'b1; mem_data = 32'hA000_0000; #1;
    chk("wait0_req", mem_req, 1'b0);
    tick(); mem_ack = 1'b0; #1;
    chk("ld0_valid", inst_valid, 1'b1);
    chk("ld0_inst", inst, 32'hA000_0000);
    chk("ld0_pc", inst_pc, 32'h0);
    chk("req1", mem_req, 1'b1);
    chk("addr1", mem_addr, 32'h4);
    tick(); mem_ack = 1'b1; mem_data = 32'hA000_0001; #1;
    chk("consumed_valid", inst_valid, 1'b0);
    tick(); mem_ack = 1'b0; stall = 1'b1; #1;
    chk("ld1_inst", inst, 32'hA000_0001);
    chk("ld1_pc", inst_pc, 32'h4);
    chk("stall_req", mem_req, 1'b0);

    // Stall holds the buffer and blocks requests
    tick(); #1;
    chk("stall2_req", mem_req, 1'b0);
    chk("stall2_valid", inst_valid, 1'b1);
    chk("stall2_inst", inst, 32'hA000_0001);
    chk("stall2_pc", inst_pc, 32'h4);
    tick(); stall = 1'b0; #1;
    chk("resume_req", mem_req, 1'b1);
    chk("addr2", mem_addr, 32'h8);
    tick(); mem_ack = 1'b1; mem_data = 32'hA000_0002; #1;
    tick(); mem_ack = 1'b0; #1;
    chk("ld2_inst", inst, 32'hA000_0002);
    chk("ld2_pc", inst_pc, 32'h8);
    chk("addr3", mem_addr, 32'hC);

    // Branch while waiting; late ack must be dropped
    tick(); branch = 1'b1; target = 32'h100; #1;
    chk("br_flush", flush, 1'b1);
    tick(); branch = 1'b0; #1;
    chk("br_flush_off", flush, 1'b0);
    chk("br_valid", inst_valid, 1'b0);
    chk("disc_req", mem_req, 1'b0);
    tick();
    tick(); mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF; #1;
    chk("disc_ack_req", mem_req, 1'b0);
    tick(); mem_ack = 1'b0; #1;
    chk("disc_valid", inst_valid, 1'b0);
    chk("br_req", mem_req, 1'b1);
    chk("br_addr", mem_addr, 32'h100);

    // Jump coincident with ack
    tick(); jump = 1'b1; target = 32'h200; mem_ack = 1'b1; mem_data = 32'hBAD0_BAD0; #1;
    chk("jmp_flush", flush, 1'b1);
    chk("jmp_req", mem_req, 1'b0);
    tick(); jump = 1'b0; mem_ack = 1'b0; #1;
    chk("jmp_valid", inst_valid, 1'b0);
    chk("jmp_req2", mem_req, 1'b1);
    chk("jmp_addr", mem_addr, 32'h200);
    tick(); mem_ack = 1'b1; mem_data = 32'hA000_0003; #1;
    tick(); mem_ack = 1'b0; #1;
    chk("ld3_inst", inst, 32'hA000_0003);
    chk("ld3_pc", inst_pc, 32'h200);
    chk("addr204", mem_addr, 32'h204);

    // Misaligned redirect issued from FETCH
    branch = 1'b1; target = 32'h103; #1;
    chk("mis_req", mem_req, 1'b0);
    chk("mis_pre", misaligned, 1'b0);
    tick(); branch = 1'b0; #1;
    chk("mis_pulse", misaligned, 1'b1);
    chk("mis_addr", mem_addr, 32'h100);
    chk("mis_valid", inst_valid, 1'b0);
    tick(); #1;
    chk("mis_clear", misaligned, 1'b0);
    mem_ack = 1'b1; mem_data = 32'hA000_0004;
    tick(); mem_ack = 1'b0; #1;
    chk("ld4_inst", inst, 32'hA000_0004);
    chk("ld4_pc", inst_pc, 32'h100);

    // Wrapping reset vector, then reset asserted in WAIT
    rst = 1'b0;
    tick(); rst2 = 1'b1; #1;
    chk("rv_req", mem_req2, 1'b1);
    chk("rv_addr", mem_addr2, 32'hFFFF_FFFC);
    tick(); mem_ack2 = 1'b1; mem_data = 32'hC000_0000; #1;
    tick(); mem_ack2 = 1'b0; #1;
    chk("rv_inst", inst2, 32'hC000_0000);
    chk("rv_pc", inst_pc2, 32'hFFFF_FFFC);
    chk("wrap_addr", mem_addr2, 32'h0);
    chk("wrap_req", mem_req2, 1'b1);
    tick(); rst2 = 1'b0; #1;
    chk("mid_valid", inst_valid2, 1'b0);
    chk("mid_inst", inst2, 32'h0);
    chk("mid_pc", inst_pc2, 32'h0);
    chk("mid_addr", mem_addr2, 32'hFFFF_FFFC);
    tick(); rst2 = 1'b1; mem_ack2 = 1'b1; mem_data = 32'h5555_5555; #1;
    chk("stale_req", mem_req2, 1'b1);
    tick(); mem_ack2 = 1'b0; #1;
    chk("stale_valid", inst_valid2, 1'b0);
    chk("stale_inst", inst2, 32'h0);
    chk("stale_wait_req", mem_req2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
